// File: rtl/drive_supervisor.sv
// ============================================================================
// drive_supervisor : gates, soft-start ramps and cuts the PID drive magnitude
// before it reaches the commutator. Optional macro: LOW_BATT_CUT_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module drive_supervisor #(
  parameter int          FAST_SIM   = 0,
  parameter logic [11:0] RAMP_STEP  = 12'd16,
  parameter logic [11:0] OC_LIMIT   = 12'hC00,
  parameter logic [3:0]  OC_CNT     = 4'd8,
  parameter logic [11:0] BATT_MIN   = 12'hA98,
  parameter logic [7:0]  COOL_TICKS = 8'd64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] drv_mag_in,
  input  logic        brake_n,
  input  logic        not_pedaling,
  input  logic [11:0] curr,
  input  logic [11:0] batt,
  input  logic        smp_vld,
  output logic [11:0] drv_mag_out,
  output logic [2:0]  state,
  output logic [1:0]  fault_code
);

  localparam int TW = (FAST_SIM != 0) ? 6 : 12;

  localparam logic [1:0]  FC_NONE  = 2'b00;
  localparam logic [1:0]  FC_OC    = 2'b01;
  localparam logic [1:0]  FC_LB    = 2'b10;
  localparam logic [11:0] BIG_STEP = 12'h100;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_RAMP  = 3'd1,
    ST_RUN   = 3'd2,
    ST_BRAKE = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  state_t      r_state, w_state;
  logic [11:0] r_drv, w_drv;
  logic [1:0]  r_fc, w_fc;
  logic [7:0]  r_cool, w_cool;
  logic [3:0]  r_oc_cnt;
  logic [TW-1:0] r_tick_cnt;
  logic        w_tick;
  logic        w_oc_trig;
  logic        w_lb_trig;
  logic        w_fault_trig;
  logic [12:0] w_ramp_sum;
  logic [11:0] w_step_up;

  // Free-running tick timebase; only rst_n clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + {{(TW-1){1'b0}}, 1'b1};
    end
  end

  assign w_tick = &r_tick_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oc_cnt <= 4'd0;
    end else if (smp_vld) begin
      if (curr > OC_LIMIT) begin
        r_oc_cnt <= (r_oc_cnt == OC_CNT) ? OC_CNT : r_oc_cnt + 4'd1;
      end else begin
        r_oc_cnt <= 4'd0;
      end
    end
  end

  assign w_oc_trig = (r_oc_cnt == OC_CNT);

`ifdef LOW_BATT_CUT_EN
  // Registered like the OC count so both causes on one sample line up and OC wins.
  logic r_lb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lb <= 1'b0;
    end else if (smp_vld) begin
      r_lb <= (batt < BATT_MIN);
    end
  end

  assign w_lb_trig = r_lb;
`else
  logic w_unused_batt;

  assign w_unused_batt = ^{batt, BATT_MIN};
  assign w_lb_trig     = 1'b0;
`endif

  assign w_fault_trig = w_oc_trig | w_lb_trig;
  assign w_ramp_sum   = {1'b0, r_drv} + {1'b0, RAMP_STEP};
  assign w_step_up    = drv_mag_in - r_drv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_OFF;
      r_drv   <= 12'd0;
      r_fc    <= FC_NONE;
      r_cool  <= 8'd0;
    end else begin
      r_state <= w_state;
      r_drv   <= w_drv;
      r_fc    <= w_fc;
      r_cool  <= w_cool;
    end
  end

  always_comb begin
    w_state = r_state;
    w_drv   = r_drv;
    w_fc    = r_fc;
    w_cool  = r_cool;

    if ((r_state != ST_FAULT) && w_fault_trig) begin
      w_state = ST_FAULT;
      w_drv   = 12'd0;
      w_fc    = w_oc_trig ? FC_OC : FC_LB;
      w_cool  = 8'd0;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_drv = 12'd0;
          if (!brake_n) begin
            w_state = ST_BRAKE;
          end else if (!not_pedaling && (drv_mag_in != 12'd0)) begin
            w_state = ST_RAMP;
          end
        end

        ST_RAMP: begin
          if (!brake_n) begin
            w_state = ST_BRAKE;
            w_drv   = 12'd0;
          end else if (not_pedaling) begin
            w_state = ST_OFF;
            w_drv   = 12'd0;
          end else if (r_drv == drv_mag_in) begin
            w_state = ST_RUN;
          end else if (drv_mag_in < r_drv) begin
            w_drv = drv_mag_in;
          end else if (w_tick) begin
            w_drv = (w_ramp_sum > {1'b0, drv_mag_in}) ? drv_mag_in : w_ramp_sum[11:0];
          end
        end

        ST_RUN: begin
          if (!brake_n) begin
            w_state = ST_BRAKE;
            w_drv   = 12'd0;
          end else if (not_pedaling) begin
            w_state = ST_OFF;
            w_drv   = 12'd0;
          end else if ((drv_mag_in > r_drv) && (w_step_up > BIG_STEP)) begin
            // Large step-ups soft-start again from the present level.
            w_state = ST_RAMP;
          end else begin
            w_drv = drv_mag_in;
          end
        end

        ST_BRAKE: begin
          w_drv = 12'd0;
          if (brake_n) begin
            w_state = ST_OFF;
          end
        end

        ST_FAULT: begin
          w_drv = 12'd0;
          if (w_tick && (r_cool < COOL_TICKS)) begin
            w_cool = r_cool + 8'd1;
          end
          if ((r_cool == COOL_TICKS) && not_pedaling) begin
            w_state = ST_OFF;
            w_fc    = FC_NONE;
          end
        end

        default: begin
          w_state = ST_OFF;
          w_drv   = 12'd0;
        end
      endcase
    end
  end

  assign drv_mag_out = r_drv;
  assign state       = r_state;
  assign fault_code  = r_fc;

endmodule

`default_nettype wire

// File: tb/tb_drive_supervisor.sv
// ============================================================================
// tb_drive_supervisor : directed vector bench for drive_supervisor (FAST_SIM).
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_drive_supervisor;

  logic        clk;
  logic        rst_n;
  logic [11:0] drv_mag_in;
  logic        brake_n;
  logic        not_pedaling;
  logic [11:0] curr;
  logic [11:0] batt;
  logic        smp_vld;
  logic [11:0] drv_mag_out;
  logic [2:0]  state;
  logic [1:0]  fault_code;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [11:0] din;
    logic        brk_n;
    logic        np;
    logic [11:0] exp_drv;
    logic [2:0]  exp_st;
  } vec_t;

  vec_t vecs[16];

  drive_supervisor #(.FAST_SIM(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .drv_mag_in   (drv_mag_in),
    .brake_n      (brake_n),
    .not_pedaling (not_pedaling),
    .curr         (curr),
    .batt         (batt),
    .smp_vld      (smp_vld),
    .drv_mag_out  (drv_mag_out),
    .state        (state),
    .fault_code   (fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sample(input logic [11:0] c, input logic [11:0] b);
    curr    = c;
    batt    = b;
    smp_vld = 1'b1;
    step();
    smp_vld = 1'b0;
    step();
  endtask

  initial begin
    logic [11:0] prev;
    int          nsteps;
    logic        done;

    vecs[0]  = '{12'h180, 1'b1, 1'b0, 12'h180, 3'd2};
    vecs[1]  = '{12'h080, 1'b1, 1'b0, 12'h080, 3'd2};
    vecs[2]  = '{12'h180, 1'b1, 1'b0, 12'h180, 3'd2};
    vecs[3]  = '{12'h300, 1'b1, 1'b0, 12'h180, 3'd1};
    vecs[4]  = '{12'h100, 1'b1, 1'b0, 12'h100, 3'd1};
    vecs[5]  = '{12'h100, 1'b1, 1'b0, 12'h100, 3'd2};
    vecs[6]  = '{12'h300, 1'b1, 1'b0, 12'h100, 3'd1};
    vecs[7]  = '{12'h300, 1'b0, 1'b0, 12'h000, 3'd3};
    vecs[8]  = '{12'h300, 1'b0, 1'b0, 12'h000, 3'd3};
    vecs[9]  = '{12'h300, 1'b1, 1'b0, 12'h000, 3'd0};
    vecs[10] = '{12'h300, 1'b1, 1'b0, 12'h000, 3'd1};
    vecs[11] = '{12'h300, 1'b1, 1'b1, 12'h000, 3'd0};
    vecs[12] = '{12'h300, 1'b1, 1'b1, 12'h000, 3'd0};
    vecs[13] = '{12'h300, 1'b0, 1'b1, 12'h000, 3'd3};
    vecs[14] = '{12'h300, 1'b1, 1'b1, 12'h000, 3'd0};
    vecs[15] = '{12'h000, 1'b1, 1'b0, 12'h000, 3'd0};

    rst_n        = 1'b0;
    drv_mag_in   = 12'h000;
    brake_n      = 1'b1;
    not_pedaling = 1'b1;
    curr         = 12'h000;
    batt         = 12'hFFF;
    smp_vld      = 1'b0;
    repeat (3) step();
    check("reset_state", state, 3'd0);
    check("reset_drv", drv_mag_out, 12'h000);
    check("reset_fault", fault_code, 2'b00);
    rst_n = 1'b1;
    step();

    // Soft-start to 0x100
    drv_mag_in   = 12'h100;
    not_pedaling = 1'b0;
    step();
    check("off_to_ramp_state", state, 3'd1);
    check("off_to_ramp_drv", drv_mag_out, 12'h000);
    prev   = 12'h000;
    nsteps = 0;
    done   = 1'b0;
    for (int i = 0; i < 16 * 64 + 200 && !done; i++) begin
      step();
      if (state == 3'd2) begin
        done = 1'b1;
      end else if (drv_mag_out != prev) begin
        check("ramp_step", drv_mag_out, prev + 12'd16);
        prev = drv_mag_out;
        nsteps++;
      end
    end
    check("ramp_reached_run", done, 1'b1);
    check("ramp_final_drv", drv_mag_out, 12'h100);
    check("ramp_step_count", nsteps, 16);

    for (int v = 0; v < 16; v++) begin
      drv_mag_in   = vecs[v].din;
      brake_n      = vecs[v].brk_n;
      not_pedaling = vecs[v].np;
      step();
      check($sformatf("vec%0d_drv", v), drv_mag_out, vecs[v].exp_drv);
      check($sformatf("vec%0d_state", v), state, vecs[v].exp_st);
    end

    // Over-current: unstrobed high readings ignored, 7 high + 1 low -> no fault
    curr = 12'hD00;
    repeat (20) step();
    for (int i = 0; i < 7; i++) sample(12'hD00, 12'hFFF);
    sample(12'h400, 12'hFFF);
    repeat (4) step();
    check("oc_7_then_low_state", state, 3'd0);
    check("oc_7_then_low_fault", fault_code, 2'b00);
    for (int i = 0; i < 8; i++) sample(12'hD00, 12'hFFF);
    check("oc_fault_state", state, 3'd4);
    check("oc_fault_code", fault_code, 2'b01);
    check("oc_fault_drv", drv_mag_out, 12'h000);
    sample(12'h000, 12'hFFF);

    // Cooldown not yet elapsed: not_pedaling cannot exit
    not_pedaling = 1'b1;
    repeat (10) step();
    check("cool_early_state", state, 3'd4);
    not_pedaling = 1'b0;
    repeat (64 * 64 + 100) step();
    check("cool_pedaling_state", state, 3'd4);
    check("cool_pedaling_fault", fault_code, 2'b01);
    not_pedaling = 1'b1;
    step();
    check("fault_exit_state", state, 3'd0);
    check("fault_exit_code", fault_code, 2'b00);

    sample(12'h000, 12'hA00);
    step();
`ifdef LOW_BATT_CUT_EN
    check("lowbatt_state", state, 3'd4);
    check("lowbatt_code", fault_code, 2'b10);
`else
    check("lowbatt_ignored_state", state, 3'd0);
    check("lowbatt_ignored_code", fault_code, 2'b00);
`endif
    batt = 12'hFFF;

    // Asynchronous reset mid-ramp at 0x060
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sample(12'h000, 12'hFFF);
    drv_mag_in   = 12'h100;
    brake_n      = 1'b1;
    not_pedaling = 1'b0;
    done         = 1'b0;
    for (int i = 0; i < 8 * 64 + 100 && !done; i++) begin
      step();
      if (drv_mag_out == 12'h060) done = 1'b1;
    end
    check("async_ramp_reached_60", done, 1'b1);
    check("async_pre_state", state, 3'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_drv", drv_mag_out, 12'h000);
    check("async_rst_state", state, 3'd0);
    check("async_rst_fault", fault_code, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
